// File: rtl/serial_subn.sv
// Bit-serial subtractor: q = a - b - bin, one bit per clock, LSB first,
// through a single full-subtractor slice with shift registers for operands and result.
module serial_subn #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             bout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  // Single full-subtractor slice on the current LSBs
  logic             diff_bit;
  logic             brw_next;
  logic [WIDTH-1:0] work_next;

  always_comb begin
    diff_bit  = sa_q[0] ^ sb_q[0] ^ brw_q;
    brw_next  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & brw_q);
    work_next = {diff_bit, work_q[WIDTH-1:1]};
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    work_d  = work_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
    ready_d = ready_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = ST_RUN;
          ready_d = 1'b0;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        brw_d  = brw_next;
        work_d = work_next;
        sa_d   = {1'b0, sa_q[WIDTH-1:1]};
        sb_d   = {1'b0, sb_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_d   = work_next;
          bout_d  = brw_next;
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      work_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      work_q  <= work_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign q     = res_q;
  assign bout  = bout_q;

endmodule

// File: tb/tb_serial_subn.sv
// Randomized and directed bench for serial_subn against a cycle-count
// reference model that computes results with plain 9-bit arithmetic.
module tb_serial_subn;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] q;
  logic             bout;

  int n_checks = 0;
  int n_errors = 0;

  serial_subn #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .done  (done),
    .q     (q),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: an op is busy for WIDTH edges after its accept edge
  int               m_busy = 0;
  logic [WIDTH:0]   m_pend = '0;
  logic [WIDTH-1:0] m_q = '0;
  logic             m_bout = 1'b0;
  logic             m_done = 1'b0;
  int               m_ops = 0;
  bit               chk_en = 1'b0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_busy = 0;
      m_q    = '0;
      m_bout = 1'b0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        {m_bout, m_q} = m_pend;
        m_done = 1'b1;
        m_ops++;
      end
    end else if (start) begin
      m_pend = (WIDTH+1)'({1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin});
      m_busy = WIDTH;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 32'(ready), 32'(m_busy == 0));
      check("done",  32'(done),  32'(m_done));
      check("q",     32'(q),     32'(m_q));
      check("bout",  32'(bout),  32'(m_bout));
    end
  end

  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tbin, input logic [WIDTH-1:0] eq, input logic eb);
    bit found = 1'b0;
    int low = 0;
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tb; bin = ~tbin;
    for (int i = 0; i < 20 && !found; i++) begin
      if (done) found = 1'b1;
      else begin
        if (!ready) low++;
        @(negedge clk);
      end
    end
    check("op_timeout", 32'(found), 32'd1);
    check("ready_low_cycles", 32'(low), 32'(WIDTH));
    check("op_q", 32'(q), 32'(eq));
    check("op_bout", 32'(bout), 32'(eb));
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done",  32'(done),  32'd0);
    check("rst_q",     32'(q),     32'd0);
    check("rst_bout",  32'(bout),  32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_op(8'h5A, 8'h27, 1'b0, 8'h33, 1'b0);
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run_op(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

    // start held high with operands changing every cycle
    start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    // reset on the 4th RUN edge discards the op
    a = 8'hFF; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_q",     32'(q),     32'd0);
    check("abort_bout",  32'(bout),  32'd0);
    repeat (12) @(negedge clk);

    // randomized traffic, including requests issued mid-RUN
    guard = 0;
    m_ops = 0;
    while (m_ops < 210 && guard < 20000) begin
      start = ($urandom_range(0, 3) != 0);
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    check("random_ops_done", 32'(m_ops >= 210), 32'd1);
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
